// File: rtl/rps_pkg.sv
// -----------------------------------------------------------------------------
// rps_pkg
// Shared constants and helpers for the rotating-priority arbiter.
//   MODE_COUNTER / MODE_RR : values for the arbiter MODE parameter.
//   inc_mod()              : modulo-n increment, n a power of two.
// Optional feature macro used elsewhere in this slice: RPS_LOCK_EN.
// -----------------------------------------------------------------------------
package rps_pkg;

   localparam int MODE_COUNTER = 32'sd0;   // pointer advances every enabled cycle
   localparam int MODE_RR      = 32'sd1;   // pointer moves to one past the winner

   // n is always a power of two, so a mask gives the wrap without a divider.
   function automatic logic [31:0] inc_mod(input logic [31:0] value,
                                           input logic [31:0] n);
      return (value + 32'd1) & (n - 32'd1);
   endfunction

endpackage

// File: rtl/rps_prio_find.sv
// -----------------------------------------------------------------------------
// rps_prio_find
// Combinational rotating find-first-set: the request at index 'base' has the
// highest priority, then base+1, ... wrapping to base-1.
// Ports:
//   req    in  [NUM_REQ-1:0]  request vector
//   base   in  [PTR_W-1:0]    highest-priority index
//   onehot out [NUM_REQ-1:0]  one-hot winner, zero when no request
//   idx    out [PTR_W-1:0]    winner index, zero when no request
//   found  out                any request present
// -----------------------------------------------------------------------------
module rps_prio_find
   import rps_pkg::*;
#(
   parameter int NUM_REQ = 8,
   parameter int PTR_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [PTR_W-1:0]   base,
   output logic [NUM_REQ-1:0] onehot,
   output logic [PTR_W-1:0]   idx,
   output logic               found
);

   localparam logic [NUM_REQ-1:0] BIT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

   logic [NUM_REQ-1:0] rot_s;
   logic [PTR_W-1:0]   ffs_s;
   logic               hit_s;

   // Rotate so the requester at index base lands on bit 0.
   always_comb begin
      rot_s = NUM_REQ'({req, req} >> base);
   end

   // Lowest set bit of the rotated vector; scanning downward leaves the lowest hit.
   always_comb begin
      ffs_s = {PTR_W{1'b0}};
      hit_s = 1'b0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         ffs_s = rot_s[i] ? PTR_W'(i) : ffs_s;
         hit_s = rot_s[i] | hit_s;
      end
   end

   // Un-rotate; the PTR_W-bit add wraps modulo NUM_REQ since it is a power of two.
   always_comb begin
      found = hit_s;
      if (hit_s) begin
         idx    = ffs_s + base;
         onehot = BIT0 << (ffs_s + base);
      end else begin
         idx    = {PTR_W{1'b0}};
         onehot = {NUM_REQ{1'b0}};
      end
   end

endmodule

// File: rtl/rps_rr_arb.sv
// -----------------------------------------------------------------------------
// rps_rr_arb
// Parametrised rotating-priority arbiter. Grants at most one of NUM_REQ
// requesters per cycle; the priority origin is the registered pointer 'count',
// which advances every enabled cycle (MODE_COUNTER) or to one past the last
// winner (MODE_RR).
// Optional feature: define RPS_LOCK_EN to add the 'lock' input, which holds the
// current grant (and freezes the pointer) until lock drops or the held
// requester withdraws.
// Ports:
//   clock     in                rising-edge clock
//   reset     in                asynchronous active-low reset
//   req       in  [NUM_REQ-1:0] request vector
//   en        in                arbitration enable, 0 forces no grant
//   gnt       out [NUM_REQ-1:0] one-hot grant (combinational)
//   gnt_valid out               OR of gnt
//   gnt_idx   out [PTR_W-1:0]   granted index, 0 when no grant
//   count     out [PTR_W-1:0]   priority pointer (registered)
//   lock      in                hold current grant (RPS_LOCK_EN only)
// -----------------------------------------------------------------------------
module rps_rr_arb
   import rps_pkg::*;
#(
   parameter  int NUM_REQ = 8,
   parameter  int MODE    = MODE_COUNTER,
   localparam int PTR_W   = $clog2(NUM_REQ)
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [NUM_REQ-1:0] req,
   input  logic               en,
   output logic [NUM_REQ-1:0] gnt,
   output logic               gnt_valid,
   output logic [PTR_W-1:0]   gnt_idx,
   output logic [PTR_W-1:0]   count
`ifdef RPS_LOCK_EN
   ,
   input  logic               lock
`endif
);

   localparam logic [NUM_REQ-1:0] BIT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

   logic               lock_s;
   logic [PTR_W-1:0]   count_r;
   logic [PTR_W-1:0]   count_nxt_s;
   logic               locked_r;
   logic               locked_nxt_s;
   logic [PTR_W-1:0]   lock_idx_r;
   logic [PTR_W-1:0]   lock_idx_nxt_s;
   logic [NUM_REQ-1:0] find_onehot_s;
   logic [PTR_W-1:0]   find_idx_s;
   logic               find_found_s;

`ifdef RPS_LOCK_EN
   assign lock_s = lock;
`else
   // Without the lock feature the locked state is never entered.
   assign lock_s = 1'b0;
`endif

   assign count = count_r;

   rps_prio_find #(
      .NUM_REQ (NUM_REQ),
      .PTR_W   (PTR_W)
   ) u_prio_find (
      .req    (req),
      .base   (count_r),
      .onehot (find_onehot_s),
      .idx    (find_idx_s),
      .found  (find_found_s)
   );

   // Grant outputs: a held lock pins the grant to the stored index only.
   always_comb begin
      gnt       = {NUM_REQ{1'b0}};
      gnt_idx   = {PTR_W{1'b0}};
      gnt_valid = 1'b0;
      if (!en) begin
         gnt_valid = 1'b0;
      end else if (locked_r) begin
         if (req[lock_idx_r]) begin
            gnt       = BIT0 << lock_idx_r;
            gnt_idx   = lock_idx_r;
            gnt_valid = 1'b1;
         end else begin
            gnt_valid = 1'b0;
         end
      end else begin
         gnt       = find_onehot_s;
         gnt_idx   = find_idx_s;
         gnt_valid = find_found_s;
      end
   end

   // Pointer and lock next-state.
   always_comb begin
      count_nxt_s    = count_r;
      locked_nxt_s   = locked_r;
      lock_idx_nxt_s = lock_idx_r;
      if (locked_r) begin
         // With en low the lock is retained regardless of lock/req.
         if (en && (!lock_s || !req[lock_idx_r])) begin
            locked_nxt_s = 1'b0;
            if (MODE == MODE_RR) begin
               count_nxt_s = PTR_W'(inc_mod(32'(lock_idx_r), 32'(NUM_REQ)));
            end else begin
               count_nxt_s = PTR_W'(inc_mod(32'(count_r), 32'(NUM_REQ)));
            end
         end else begin
            locked_nxt_s = 1'b1;
         end
      end else if (gnt_valid && lock_s) begin
         // Entering the lock freezes the pointer where it is.
         locked_nxt_s   = 1'b1;
         lock_idx_nxt_s = gnt_idx;
      end else if (MODE == MODE_RR) begin
         if (gnt_valid) begin
            count_nxt_s = PTR_W'(inc_mod(32'(gnt_idx), 32'(NUM_REQ)));
         end else begin
            count_nxt_s = count_r;
         end
      end else begin
         if (en) begin
            count_nxt_s = PTR_W'(inc_mod(32'(count_r), 32'(NUM_REQ)));
         end else begin
            count_nxt_s = count_r;
         end
      end
   end

   // State registers.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         count_r    <= {PTR_W{1'b0}};
         locked_r   <= 1'b0;
         lock_idx_r <= {PTR_W{1'b0}};
      end else begin
         count_r    <= count_nxt_s;
         locked_r   <= locked_nxt_s;
         lock_idx_r <= lock_idx_nxt_s;
      end
   end

endmodule

// File: tb/tb_rps_rr_arb.sv
// -----------------------------------------------------------------------------
// tb_rps_rr_arb
// Three arbiter instances (4-way counter, 4-way round-robin, 8-way round-robin)
// driven by directed steps and then random traffic, each compared against a
// behavioural model that walks the rotation order directly.
// -----------------------------------------------------------------------------
module tb_rps_rr_arb;

`ifdef RPS_LOCK_EN
   localparam bit LOCK_ON = 1'b1;
`else
   localparam bit LOCK_ON = 1'b0;
`endif

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic       reset;
   logic [3:0] req_c4, req_r4;
   logic [7:0] req_r8;
   logic       en_c4, en_r4, en_r8;
   logic       lock_c4, lock_r4, lock_r8;

   logic [3:0] gnt_c4, gnt_r4;
   logic [7:0] gnt_r8;
   logic       gv_c4, gv_r4, gv_r8;
   logic [1:0] gi_c4, gi_r4, cnt_c4, cnt_r4;
   logic [2:0] gi_r8, cnt_r8;

   int checks = 0;
   int errors = 0;

   // model state per instance: 0 = c4, 1 = r4, 2 = r8
   int m_cnt [3];
   bit m_lk  [3];
   int m_st  [3];

   rps_rr_arb #(.NUM_REQ(4), .MODE(0)) u_c4 (
      .clock(clock), .reset(reset), .req(req_c4), .en(en_c4),
      .gnt(gnt_c4), .gnt_valid(gv_c4), .gnt_idx(gi_c4), .count(cnt_c4)
`ifdef RPS_LOCK_EN
      , .lock(lock_c4)
`endif
   );

   rps_rr_arb #(.NUM_REQ(4), .MODE(1)) u_r4 (
      .clock(clock), .reset(reset), .req(req_r4), .en(en_r4),
      .gnt(gnt_r4), .gnt_valid(gv_r4), .gnt_idx(gi_r4), .count(cnt_r4)
`ifdef RPS_LOCK_EN
      , .lock(lock_r4)
`endif
   );

   rps_rr_arb #(.NUM_REQ(8), .MODE(1)) u_r8 (
      .clock(clock), .reset(reset), .req(req_r8), .en(en_r8),
      .gnt(gnt_r8), .gnt_valid(gv_r8), .gnt_idx(gi_r8), .count(cnt_r8)
`ifdef RPS_LOCK_EN
      , .lock(lock_r8)
`endif
   );

   function automatic int nreq(input int i);
      return (i == 2) ? 8 : 4;
   endfunction

   function automatic int mode(input int i);
      return (i == 0) ? 0 : 1;
   endfunction

   function automatic logic [7:0] cur_req(input int i);
      case (i)
         0:       return {4'd0, req_c4};
         1:       return {4'd0, req_r4};
         default: return req_r8;
      endcase
   endfunction

   function automatic logic cur_en(input int i);
      case (i)
         0:       return en_c4;
         1:       return en_r4;
         default: return en_r8;
      endcase
   endfunction

   function automatic logic cur_lock(input int i);
      case (i)
         0:       return lock_c4 & LOCK_ON;
         1:       return lock_r4 & LOCK_ON;
         default: return lock_r8 & LOCK_ON;
      endcase
   endfunction

   // Winner in rotation order starting at the pointer; -1 when nothing is granted.
   function automatic int ref_idx(input int i);
      logic [7:0] r;
      int j;
      r = cur_req(i);
      if (!cur_en(i)) return -1;
      if (m_lk[i]) return r[m_st[i]] ? m_st[i] : -1;
      for (int k = 0; k < nreq(i); k++) begin
         j = (m_cnt[i] + k) % nreq(i);
         if (r[j]) return j;
      end
      return -1;
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 3; i++) begin
         m_cnt[i] = 0;
         m_lk[i]  = 1'b0;
         m_st[i]  = 0;
      end
   endtask

   task automatic model_step();
      int g;
      for (int i = 0; i < 3; i++) begin
         g = ref_idx(i);
         if (m_lk[i]) begin
            if (cur_en(i) && (!cur_lock(i) || !cur_req(i)[m_st[i]])) begin
               m_lk[i]  = 1'b0;
               m_cnt[i] = (mode(i) == 1) ? (m_st[i] + 1) % nreq(i) : (m_cnt[i] + 1) % nreq(i);
            end
         end else if (g >= 0 && cur_lock(i)) begin
            m_lk[i] = 1'b1;
            m_st[i] = g;
         end else if (mode(i) == 1) begin
            if (g >= 0) m_cnt[i] = (g + 1) % nreq(i);
         end else if (cur_en(i)) begin
            m_cnt[i] = (m_cnt[i] + 1) % nreq(i);
         end
      end
   endtask

   task automatic tick();
      @(posedge clock);
      if (reset) model_step();
      @(negedge clock);
   endtask

   task automatic check(input string tag, input int i, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s inst=%0d observed=%0h expected=%0h", tag, i, obs, exp);
      end
   endtask

   task automatic read_dut(input int i, output logic [7:0] g, output logic [7:0] v,
                           output logic [7:0] ix, output logic [7:0] c);
      case (i)
         0: begin g = {4'd0, gnt_c4}; v = {7'd0, gv_c4}; ix = {6'd0, gi_c4}; c = {6'd0, cnt_c4}; end
         1: begin g = {4'd0, gnt_r4}; v = {7'd0, gv_r4}; ix = {6'd0, gi_r4}; c = {6'd0, cnt_r4}; end
         default: begin g = gnt_r8; v = {7'd0, gv_r8}; ix = {5'd0, gi_r8}; c = {5'd0, cnt_r8}; end
      endcase
   endtask

   task automatic check_all();
      logic [7:0] g, v, ix, c;
      int e;
      for (int i = 0; i < 3; i++) begin
         read_dut(i, g, v, ix, c);
         e = ref_idx(i);
         check("model_gnt", i, g, (e >= 0) ? 8'(1 << e) : 8'd0);
         check("model_valid", i, v, (e >= 0) ? 8'd1 : 8'd0);
         check("model_idx", i, ix, (e >= 0) ? 8'(e) : 8'd0);
         check("model_count", i, c, 8'(m_cnt[i]));
      end
   endtask

   // Directly stated expectations, independent of the model.
   task automatic expect_dut(input string tag, input int i, input logic [7:0] eg, input logic [7:0] ec);
      logic [7:0] g, v, ix, c;
      read_dut(i, g, v, ix, c);
      check({tag, "_gnt"}, i, g, eg);
      check({tag, "_count"}, i, c, ec);
   endtask

   task automatic reset_pulse();
      #1;
      reset = 1'b0;
      model_clear();
      #1;
      check_all();
      reset = 1'b1;
   endtask

   initial begin
      reset  = 1'b0;
      req_c4 = 4'b1111; en_c4 = 1'b1; lock_c4 = 1'b0;
      req_r4 = 4'b1010; en_r4 = 1'b1; lock_r4 = 1'b0;
      req_r8 = 8'h40;   en_r8 = 1'b1; lock_r8 = 1'b0;
      model_clear();

      // reset held across edges: pointer stays at 0, grants follow count = 0
      repeat (2) @(posedge clock);
      @(negedge clock);
      expect_dut("rst", 0, 8'h01, 8'd0);
      check_all();
      reset = 1'b1;

      // counter rotation, round-robin alternation, 8-way wrap at index 7
      for (int k = 0; k < 8; k++) begin
         en_c4  = (k < 6) ? 1'b1 : 1'b0;
         req_r8 = (k == 0) ? 8'h40 : 8'h81;
         #1;
         check_all();
         expect_dut("ctr", 0, (k < 6) ? 8'(1 << (k % 4)) : 8'd0, (k < 6) ? 8'(k % 4) : 8'd2);
         expect_dut("rr4", 1, (k % 2 == 1) ? 8'h08 : 8'h02, (k % 2 == 1) ? 8'd2 : 8'd0);
         if (k == 1) expect_dut("rr8_wrap", 2, 8'h80, 8'd7);
         if (k == 2) expect_dut("rr8_zero", 2, 8'h01, 8'd0);
         tick();
      end

`ifdef RPS_LOCK_EN
      en_c4 = 1'b0; en_r8 = 1'b0;
      reset_pulse();
      req_r4 = 4'b0001; #1; check_all(); tick();
      req_r4 = 4'b0110; lock_r4 = 1'b1;
      for (int k = 0; k < 3; k++) begin
         #1;
         check_all();
         expect_dut("lock_hold", 1, 8'h02, 8'd1);
         tick();
      end
      lock_r4 = 1'b0; #1; check_all(); expect_dut("lock_drop", 1, 8'h02, 8'd1); tick();
      lock_r4 = 1'b1; #1; check_all(); expect_dut("lock_resume", 1, 8'h04, 8'd2); tick();
      #2;
      reset = 1'b0;
      model_clear();
      #1;
      check_all();
      expect_dut("lock_reset", 1, 8'h02, 8'd0);
      reset = 1'b1;
      lock_r4 = 1'b0;
      tick();
`endif

      // random traffic with occasional asynchronous reset between edges
      for (int n = 0; n < 400; n++) begin
         req_c4  = 4'($urandom);
         req_r4  = 4'($urandom);
         req_r8  = 8'($urandom) & 8'($urandom);
         en_c4   = ($urandom_range(7, 0) != 0);
         en_r4   = ($urandom_range(7, 0) != 0);
         en_r8   = ($urandom_range(7, 0) != 0);
         lock_c4 = ($urandom_range(3, 0) == 0);
         lock_r4 = ($urandom_range(3, 0) == 0);
         lock_r8 = ($urandom_range(3, 0) == 0);
         #1;
         check_all();
         if ($urandom_range(49, 0) == 0) reset_pulse();
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/rps_rr_arb.md
Name: rps_rr_arb

Overview:
- Parametrised rotating-priority arbiter; successor to the fixed 4-requester rotating selector.
- Grants at most one of NUM_REQ requesters per cycle.
- Priority origin held in a registered pointer that rotates either every cycle (counter mode) or to one past the last winner (round-robin mode).
- Sits in front of shared resources (bus ports, functional units) where fair, starvation-free selection is needed.

Parameters:
- NUM_REQ, 8, number of requesters; power of 2, >= 2.
- MODE, 0, 0 = counter rotation; 1 = round-robin rotation.
- PTR_W, $clog2(NUM_REQ), derived localparam; width of pointer and index (not overridable).

Ports:
- clock  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset; asserted when 0.
- req  in  NUM_REQ  request vector; bit i = requester i.
- en  in  1  arbitration enable; 0 forces no grant.
- gnt  out  NUM_REQ  one-hot grant, or all-zero; combinational from req/en/state.
- gnt_valid  out  1  OR of gnt.
- gnt_idx  out  PTR_W  index of granted requester; 0 when gnt_valid = 0.
- count  out  PTR_W  current priority pointer, registered.
- lock  in  1  present only with RPS_LOCK_EN; holds current grant.

Behaviour:
- Reset (reset = 0, async):
  - count = 0; lock state cleared.
  - gnt, gnt_valid, gnt_idx follow combinational rules with count = 0.
  - Reset mid-cycle takes effect immediately; the next rising edge after release is the first update.
- Priority order:
  - Highest priority is index count, then count+1, ... up to NUM_REQ-1, wrapping to 0, ending at count-1.
  - gnt = first requesting index in that order, gated by en.
  - Zero-latency: the grant appears in the same cycle as req.
- en = 0 or req = 0: gnt = 0, gnt_valid = 0, gnt_idx = 0.
- MODE 0 (counter):
  - When en = 1, count <= count + 1 every clock, independent of req.
  - Wraps NUM_REQ-1 -> 0, modulo 2^PTR_W.
  - When en = 0, count holds.
- MODE 1 (round-robin):
  - When gnt_valid = 1, count <= gnt_idx + 1 mod NUM_REQ.
  - Otherwise count holds.
  - A requester granted at index NUM_REQ-1 moves the pointer to 0.
- Simultaneous requests: resolved purely by rotation order; no ties are possible.
- Starvation bound:
  - MODE 1: a continuously asserted request is granted within NUM_REQ arbitration cycles while en = 1.
  - MODE 0: granted within NUM_REQ cycles when it is the only requester, and always when count equals its index.
- Outputs are pure functions of count, lock state, req and en; no X propagation is permitted from unused states.

Optional Feature:
- Macro RPS_LOCK_EN.
- Defined:
  - lock port exists. If gnt_valid = 1 and lock = 1 at a rising edge, the arbiter enters the locked state, stores gnt_idx and freezes count.
  - While locked, gnt stays on the stored index as long as req[stored] = 1 and en = 1; all other requests are ignored.
  - Lock releases on the first edge where lock = 0 or req[stored] = 0. Normal pointer update resumes on that edge, using the stored index in MODE 1 or an increment in MODE 0.
  - en = 0 while locked: gnt = 0; lock is retained.
  - Reset clears the lock.
- Undefined: no lock port; arbiter behaves exactly as described above.

Decomposition:
- Package rps_pkg holds:
  - MODE_COUNTER = 0 and MODE_RR = 1 constants.
  - Helper function for a modulo-NUM_REQ increment.
- One natural sub-module, rps_prio_find:
  - Combinational rotate-by-count, find-first-set, un-rotate.
  - Outputs one-hot and index.
- The top level holds count, lock registers and mode logic.

Test Plan:
- Reset check (NUM_REQ = 4): hold reset = 0 with req = 4'b1111 and en = 1 -> count = 0, gnt = 4'b0001, gnt_idx = 0. Release reset -> count unchanged until the first edge.
- MODE 0, NUM_REQ = 4, en = 1, req = 4'b1111 for 6 cycles:
  - count = 0, 1, 2, 3, 0, 1.
  - gnt = 0001, 0010, 0100, 1000, 0001, 0010.
  - Drop en for 2 cycles -> gnt = 0, count holds at 2.
- MODE 1, NUM_REQ = 4, req = 4'b1010 steady:
  - gnt alternates 0010 (count 0), 1000 (count 2), 0010 (count 0).
  - Each requester granted every 2 cycles.
- MODE 1, NUM_REQ = 8, count = 7, req = 8'b1000_0001 -> gnt = 8'b1000_0000, gnt_idx = 7, next count = 0. Next cycle gnt = 8'b0000_0001.
- RPS_LOCK_EN, MODE 1, NUM_REQ = 4, req = 4'b0110, lock = 1 while index 1 is granted:
  - gnt stays 0010 for 3 cycles; count frozen at 1.
  - Drop lock -> count becomes 2 and gnt = 0100 the next cycle.
- Async reset asserted mid-lock, between edges -> lock cleared immediately, count = 0, gnt = 0010 with req = 4'b0110.
